// File: rtl/pixel_color_detect.sv
// pixel_color_detect: reads RGB565 words from the camera FIFO, classifies
// each pixel against per-channel inclusive windows, optionally highlights
// matches, and writes the result to a linear frame-buffer address.
// Build option: define PIXEL_COLOR_DETECT_BBOX_EN to add per-frame match
// statistics (bounding box, match count, hit flag). Without it the
// statistic outputs are tied to zero and the pixel path is identical.
module pixel_color_detect #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_sof,
  input  logic        i_mode,
  input  logic [4:0]  i_r_min,
  input  logic [4:0]  i_r_max,
  input  logic [5:0]  i_g_min,
  input  logic [5:0]  i_g_max,
  input  logic [4:0]  i_b_min,
  input  logic [4:0]  i_b_max,
  output logic        o_rd,
  input  logic [15:0] i_rdata,
  input  logic        i_almostempty,
  output logic        o_valid,
  output logic [18:0] o_addr,
  output logic [15:0] o_data,
  output logic        o_bbox_valid,
  output logic        o_hit,
  output logic [9:0]  o_xmin,
  output logic [9:0]  o_xmax,
  output logic [8:0]  o_ymin,
  output logic [8:0]  o_ymax,
  output logic [18:0] o_count
);

  localparam logic [18:0] LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [15:0] HIGHLIGHT = 16'h07E0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic        s1_valid;
  logic [18:0] addr_cnt;

  logic [4:0]  px_r;
  logic [5:0]  px_g;
  logic [4:0]  px_b;
  logic        px_match;
  logic [15:0] px_out;

  // Read-control FSM: IDLE until start-of-frame, then read whenever the FIFO is not almost empty
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_rd  <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
      o_rd  <= 1'b0;
    end else begin
      if (i_sof) begin
        state <= RUN;
      end
      o_rd <= (i_sof || (state == RUN)) && !i_almostempty;
    end
  end

  // Capture stage: marks the cycle in which i_rdata carries the word requested by o_rd
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= o_rd;
    end
  end

  // Classification: a channel with min > max can never satisfy both bounds
  always_comb begin
    px_r     = i_rdata[15:11];
    px_g     = i_rdata[10:5];
    px_b     = i_rdata[4:0];
    px_match = (px_r >= i_r_min) && (px_r <= i_r_max) &&
               (px_g >= i_g_min) && (px_g <= i_g_max) &&
               (px_b >= i_b_min) && (px_b <= i_b_max);
    px_out   = (i_mode && px_match) ? HIGHLIGHT : i_rdata;
  end

  // Classify stage: registered frame-buffer write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_addr <= addr_cnt;
        o_data <= px_out;
      end
    end
  end

  // Write address of the next emitted pixel; sof restarts it after the pixel emitted in the same cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_cnt <= '0;
    end else if (i_flush || i_sof) begin
      addr_cnt <= '0;
    end else if (s1_valid) begin
      addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 19'd1;
    end
  end

`ifdef PIXEL_COLOR_DETECT_BBOX_EN

  localparam logic [9:0] LAST_X = 10'(H_ACTIVE - 1);
  localparam logic [8:0] LAST_Y = 9'(V_ACTIVE - 1);

  // x/y only feed the statistics, so they are built together with them
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;
  logic        frame_end;

  logic [9:0]  acc_xmin, acc_xmax, nx_xmin, nx_xmax, fin_xmin, fin_xmax;
  logic [8:0]  acc_ymin, acc_ymax, nx_ymin, nx_ymax, fin_ymin, fin_ymax;
  logic [18:0] acc_cnt, nx_cnt, fin_cnt;
  logic        fin_pend;
  logic        fin_hit;

  assign frame_end = s1_valid && (addr_cnt == LAST_ADDR);
  assign fin_hit   = (fin_cnt != '0);

  // Raster position of the next emitted pixel, kept in step with addr_cnt
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (i_flush || i_sof) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (s1_valid) begin
      if (x_cnt == LAST_X) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == LAST_Y) ? '0 : y_cnt + 9'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  // Accumulator values including the pixel currently being classified
  always_comb begin
    nx_xmin = acc_xmin;
    nx_xmax = acc_xmax;
    nx_ymin = acc_ymin;
    nx_ymax = acc_ymax;
    nx_cnt  = acc_cnt;
    if (s1_valid && px_match) begin
      if (x_cnt < acc_xmin) nx_xmin = x_cnt;
      if (x_cnt > acc_xmax) nx_xmax = x_cnt;
      if (y_cnt < acc_ymin) nx_ymin = y_cnt;
      if (y_cnt > acc_ymax) nx_ymax = y_cnt;
      nx_cnt = acc_cnt + 19'd1;
    end
  end

  // Running accumulators; reload to the empty state at frame end, sof or flush
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (i_flush || i_sof || frame_end) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else begin
      acc_xmin <= nx_xmin;
      acc_xmax <= nx_xmax;
      acc_ymin <= nx_ymin;
      acc_ymax <= nx_ymax;
      acc_cnt  <= nx_cnt;
    end
  end

  // Frame-end snapshot; staging it lets the next frame accumulate without a bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fin_pend <= 1'b0;
      fin_xmin <= '0;
      fin_xmax <= '0;
      fin_ymin <= '0;
      fin_ymax <= '0;
      fin_cnt  <= '0;
    end else if (i_flush) begin
      fin_pend <= 1'b0;
    end else begin
      fin_pend <= frame_end && !i_sof;
      if (frame_end && !i_sof) begin
        fin_xmin <= nx_xmin;
        fin_xmax <= nx_xmax;
        fin_ymin <= nx_ymin;
        fin_ymax <= nx_ymax;
        fin_cnt  <= nx_cnt;
      end
    end
  end

  // Published statistics; an empty frame reports all zeros, flush leaves them untouched
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bbox_valid <= 1'b0;
      o_hit        <= 1'b0;
      o_xmin       <= '0;
      o_xmax       <= '0;
      o_ymin       <= '0;
      o_ymax       <= '0;
      o_count      <= '0;
    end else if (i_flush) begin
      o_bbox_valid <= 1'b0;
    end else begin
      o_bbox_valid <= fin_pend;
      if (fin_pend) begin
        o_hit   <= fin_hit;
        o_xmin  <= fin_hit ? fin_xmin : '0;
        o_xmax  <= fin_hit ? fin_xmax : '0;
        o_ymin  <= fin_hit ? fin_ymin : '0;
        o_ymax  <= fin_hit ? fin_ymax : '0;
        o_count <= fin_cnt;
      end
    end
  end

`else

  assign o_bbox_valid = 1'b0;
  assign o_hit        = 1'b0;
  assign o_xmin       = '0;
  assign o_xmax       = '0;
  assign o_ymin       = '0;
  assign o_ymax       = '0;
  assign o_count      = '0;

`endif

endmodule

// File: tb/tb_pixel_color_detect.sv
// Directed testbench for pixel_color_detect. Two instances share all inputs:
// dut (8x4 frame) for frame statistics, dut_w (16x4 frame) for the mid-frame
// sof case, which needs addresses beyond 31.
module tb_pixel_color_detect;

  logic        clk;
  logic        rst, flush, sof, mode, ae;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic [15:0] rdata;

  logic        rd, valid, bbv, hit;
  logic [18:0] addr, count;
  logic [15:0] data;
  logic [9:0]  xmin, xmax;
  logic [8:0]  ymin, ymax;

  logic        rd_w, valid_w, bbv_w, hit_w;
  logic [18:0] addr_w, count_w;
  logic [15:0] data_w;
  logic [9:0]  xmin_w, xmax_w;
  logic [8:0]  ymin_w, ymax_w;

  int n_checks;
  int n_fail;
  int cyc;
  int rd_seen;
  int first_rd_cyc;
  int bbw_n;
  bit rd_prev;

  logic [15:0] src_q[$];
  int          v_addr[$];
  logic [15:0] v_data[$];
  int          v_cyc[$];
  int          w_addr[$];
  int          bb_cyc[$];
  logic [37:0] bb_box[$];
  int          bb_cnt[$];
  logic        bb_hit[$];

  pixel_color_detect #(.H_ACTIVE(8), .V_ACTIVE(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_sof(sof), .i_mode(mode),
    .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
    .i_b_min(b_min), .i_b_max(b_max), .o_rd(rd), .i_rdata(rdata),
    .i_almostempty(ae), .o_valid(valid), .o_addr(addr), .o_data(data),
    .o_bbox_valid(bbv), .o_hit(hit), .o_xmin(xmin), .o_xmax(xmax),
    .o_ymin(ymin), .o_ymax(ymax), .o_count(count)
  );

  pixel_color_detect #(.H_ACTIVE(16), .V_ACTIVE(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_sof(sof), .i_mode(mode),
    .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
    .i_b_min(b_min), .i_b_max(b_max), .o_rd(rd_w), .i_rdata(rdata),
    .i_almostempty(ae), .o_valid(valid_w), .o_addr(addr_w), .o_data(data_w),
    .o_bbox_valid(bbv_w), .o_hit(hit_w), .o_xmin(xmin_w), .o_xmax(xmax_w),
    .o_ymin(ymin_w), .o_ymax(ymax_w), .o_count(count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: FIFO model drives the word one cycle after o_rd, then sample at negedge
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev) rdata = (src_q.size() > 0) ? src_q.pop_front() : 16'h0000;
    @(negedge clk);
    rd_prev = rd;
    if (rd) begin
      if (rd_seen == 0) first_rd_cyc = cyc;
      rd_seen++;
    end
    if (valid) begin
      v_addr.push_back(int'(addr));
      v_data.push_back(data);
      v_cyc.push_back(cyc);
    end
    if (valid_w) w_addr.push_back(int'(addr_w));
    if (bbv) begin
      bb_cyc.push_back(cyc);
      bb_box.push_back({xmin, xmax, ymin, ymax});
      bb_cnt.push_back(int'(count));
      bb_hit.push_back(hit);
    end
    if (bbv_w) bbw_n++;
  endtask

  task automatic clear_logs();
    v_addr.delete(); v_data.delete(); v_cyc.delete(); w_addr.delete();
    bb_cyc.delete(); bb_box.delete(); bb_cnt.delete(); bb_hit.delete();
    rd_seen = 0; first_rd_cyc = -1; bbw_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sof = 1'b0; flush = 1'b0; ae = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    src_q.delete();
    clear_logs();
  endtask

  task automatic set_win(input logic [4:0] rl, input logic [4:0] rh, input logic [5:0] gl,
                         input logic [5:0] gh, input logic [4:0] bl, input logic [4:0] bh);
    r_min = rl; r_max = rh; g_min = gl; g_max = gh; b_min = bl; b_max = bh;
  endtask

  task automatic start_frame();
    sof = 1'b1; ae = 1'b0;
    cycle();
    sof = 1'b0;
  endtask

  // Read exactly n words (raise almost-empty after the n-th strobe), then drain
  task automatic stream(input int n_reads);
    int budget;
    budget = n_reads * 2 + 20;
    ae = 1'b0;
    while (rd_seen < n_reads && budget > 0) begin
      cycle();
      budget--;
    end
    ae = 1'b1;
    repeat (6) cycle();
    n_checks++;
    if (rd_seen != n_reads) begin
      n_fail++;
      $display("FAIL read_count: got %0d reads, expected %0d", rd_seen, n_reads);
    end
  endtask

  task automatic test_reset();
    cycle();
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", rd); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", addr); end
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_checks++; if (bbv !== 1'b0) begin n_fail++; $display("FAIL reset_bbox_valid: got %b expected 0", bbv); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", hit); end
    n_checks++; if ({xmin, xmax, ymin, ymax} !== 38'd0) begin n_fail++; $display("FAIL reset_box: got %h expected 0", {xmin, xmax, ymin, ymax}); end
    n_checks++; if (count !== 19'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_highlight();
    do_reset();
    mode = 1'b1;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    repeat (4) src_q.push_back(16'hFFFF);
    start_frame();
    stream(4);
    n_checks++;
    if (v_addr.size() != 4) begin n_fail++; $display("FAIL hl_valid_count: got %0d expected 4", v_addr.size()); end
    for (int i = 0; i < 4 && i < v_addr.size(); i++) begin
      n_checks++;
      if (v_addr[i] != i) begin n_fail++; $display("FAIL hl_addr[%0d]: got %0d expected %0d", i, v_addr[i], i); end
      n_checks++;
      if (v_data[i] !== 16'h07E0) begin n_fail++; $display("FAIL hl_data[%0d]: got %h expected 07e0", i, v_data[i]); end
      n_checks++;
      if (v_cyc[i] != first_rd_cyc + 2 + i) begin
        n_fail++; $display("FAIL hl_latency[%0d]: got cycle %0d expected %0d", i, v_cyc[i], first_rd_cyc + 2 + i);
      end
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    mode = 1'b0;
    set_win(5'd10, 5'd20, 6'd0, 6'd63, 5'd0, 5'd31);
    src_q.push_back(16'h5000);
    repeat (31) src_q.push_back(16'hA800);
    start_frame();
    stream(32);
    n_checks++;
    if (v_addr.size() != 32) begin n_fail++; $display("FAIL pt_valid_count: got %0d expected 32", v_addr.size()); end
    if (v_addr.size() == 32) begin
      n_checks++; if (v_data[0] !== 16'h5000) begin n_fail++; $display("FAIL pt_data0: got %h expected 5000", v_data[0]); end
      n_checks++; if (v_data[1] !== 16'hA800) begin n_fail++; $display("FAIL pt_data1: got %h expected a800", v_data[1]); end
      n_checks++; if (v_addr[31] != 31) begin n_fail++; $display("FAIL pt_last_addr: got %0d expected 31", v_addr[31]); end
    end
`ifdef PIXEL_COLOR_DETECT_BBOX_EN
    n_checks++;
    if (bb_cyc.size() != 1) begin n_fail++; $display("FAIL pt_bbox_pulses: got %0d expected 1", bb_cyc.size()); end
    if (bb_cyc.size() == 1) begin
      n_checks++; if (bb_cnt[0] != 1) begin n_fail++; $display("FAIL pt_count: got %0d expected 1", bb_cnt[0]); end
      n_checks++; if (bb_hit[0] !== 1'b1) begin n_fail++; $display("FAIL pt_hit: got %b expected 1", bb_hit[0]); end
      n_checks++; if (bb_box[0] !== 38'd0) begin n_fail++; $display("FAIL pt_box: got %h expected 0", bb_box[0]); end
      if (v_cyc.size() == 32) begin
        n_checks++;
        if (bb_cyc[0] != v_cyc[31] + 1) begin n_fail++; $display("FAIL pt_bbox_timing: got cycle %0d expected %0d", bb_cyc[0], v_cyc[31] + 1); end
      end
    end
`else
    n_checks++;
    if (bb_cyc.size() != 0) begin n_fail++; $display("FAIL pt_bbox_pulses: got %0d expected 0", bb_cyc.size()); end
    n_checks++;
    if (count !== 19'd0 || hit !== 1'b0) begin n_fail++; $display("FAIL pt_stats_tied: got count %0d hit %b expected 0 0", count, hit); end
`endif
  endtask

  task automatic test_bbox();
    logic [37:0] exp_box;
    do_reset();
    mode = 1'b0;
    set_win(5'd10, 5'd20, 6'd0, 6'd63, 5'd0, 5'd31);
    for (int i = 0; i < 32; i++) src_q.push_back((i == 19) ? 16'h5000 : 16'hA800);
    for (int i = 0; i < 32; i++) src_q.push_back((i == 9 || i == 30) ? 16'h5000 : 16'hA800);
    src_q.push_back(16'hA800);
    start_frame();
    stream(65);
    n_checks++;
    if (v_addr.size() != 65) begin n_fail++; $display("FAIL bb_valid_count: got %0d expected 65", v_addr.size()); end
    if (v_addr.size() == 65) begin
      n_checks++; if (v_addr[32] != 0) begin n_fail++; $display("FAIL bb_wrap_addr1: got %0d expected 0", v_addr[32]); end
      n_checks++; if (v_addr[64] != 0) begin n_fail++; $display("FAIL bb_wrap_addr2: got %0d expected 0", v_addr[64]); end
    end
`ifdef PIXEL_COLOR_DETECT_BBOX_EN
    n_checks++;
    if (bb_cyc.size() != 2) begin n_fail++; $display("FAIL bb_pulses: got %0d expected 2", bb_cyc.size()); end
    if (bb_cyc.size() == 2 && v_cyc.size() == 65) begin
      exp_box = {10'd3, 10'd3, 9'd2, 9'd2};
      n_checks++; if (bb_box[0] !== exp_box) begin n_fail++; $display("FAIL bb_box1: got %h expected %h", bb_box[0], exp_box); end
      n_checks++; if (bb_cnt[0] != 1) begin n_fail++; $display("FAIL bb_count1: got %0d expected 1", bb_cnt[0]); end
      n_checks++; if (bb_hit[0] !== 1'b1) begin n_fail++; $display("FAIL bb_hit1: got %b expected 1", bb_hit[0]); end
      n_checks++; if (bb_cyc[0] != v_cyc[31] + 1) begin n_fail++; $display("FAIL bb_timing1: got cycle %0d expected %0d", bb_cyc[0], v_cyc[31] + 1); end
      exp_box = {10'd1, 10'd6, 9'd1, 9'd3};
      n_checks++; if (bb_box[1] !== exp_box) begin n_fail++; $display("FAIL bb_box2: got %h expected %h", bb_box[1], exp_box); end
      n_checks++; if (bb_cnt[1] != 2) begin n_fail++; $display("FAIL bb_count2: got %0d expected 2", bb_cnt[1]); end
      n_checks++; if (bb_cyc[1] != v_cyc[63] + 1) begin n_fail++; $display("FAIL bb_timing2: got cycle %0d expected %0d", bb_cyc[1], v_cyc[63] + 1); end
    end
`else
    n_checks++;
    if (bb_cyc.size() != 0) begin n_fail++; $display("FAIL bb_pulses: got %0d expected 0", bb_cyc.size()); end
`endif
  endtask

  // Runs straight after test_bbox so the outputs hold non-zero statistics beforehand
  task automatic test_no_match();
    clear_logs();
    mode = 1'b1;
    set_win(5'd20, 5'd10, 6'd0, 6'd63, 5'd0, 5'd31);
    repeat (32) src_q.push_back(16'h5000);
    start_frame();
    stream(32);
    n_checks++;
    if (v_data.size() != 32) begin n_fail++; $display("FAIL nm_valid_count: got %0d expected 32", v_data.size()); end
    if (v_data.size() == 32) begin
      n_checks++; if (v_data[0] !== 16'h5000) begin n_fail++; $display("FAIL nm_data0: got %h expected 5000", v_data[0]); end
      n_checks++; if (v_data[31] !== 16'h5000) begin n_fail++; $display("FAIL nm_data31: got %h expected 5000", v_data[31]); end
    end
`ifdef PIXEL_COLOR_DETECT_BBOX_EN
    n_checks++;
    if (bb_cyc.size() != 1) begin n_fail++; $display("FAIL nm_pulses: got %0d expected 1", bb_cyc.size()); end
    if (bb_cyc.size() == 1) begin
      n_checks++; if (bb_hit[0] !== 1'b0) begin n_fail++; $display("FAIL nm_hit: got %b expected 0", bb_hit[0]); end
      n_checks++; if (bb_box[0] !== 38'd0) begin n_fail++; $display("FAIL nm_box: got %h expected 0", bb_box[0]); end
      n_checks++; if (bb_cnt[0] != 0) begin n_fail++; $display("FAIL nm_count: got %0d expected 0", bb_cnt[0]); end
    end
`else
    n_checks++;
    if (bb_cyc.size() != 0) begin n_fail++; $display("FAIL nm_pulses: got %0d expected 0", bb_cyc.size()); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    mode = 1'b0;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    repeat (40) src_q.push_back(16'h2222);
    start_frame();
    repeat (3) cycle();
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_during[%0d]: got %b expected 0", i, valid); end
      n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL fl_rd_during[%0d]: got %b expected 0", i, rd); end
    end
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_after[%0d]: got %b expected 0", i, valid); end
      n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL fl_rd_after[%0d]: got %b expected 0", i, rd); end
    end
    clear_logs();
    start_frame();
    stream(3);
    n_checks++;
    if (v_addr.size() != 3) begin n_fail++; $display("FAIL fl_resume_count: got %0d expected 3", v_addr.size()); end
    for (int i = 0; i < 3 && i < v_addr.size(); i++) begin
      n_checks++;
      if (v_addr[i] != i) begin n_fail++; $display("FAIL fl_resume_addr[%0d]: got %0d expected %0d", i, v_addr[i], i); end
    end
  endtask

  task automatic test_sof_mid();
    bit found;
    int k;
    do_reset();
    mode = 1'b0;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    repeat (60) src_q.push_back(16'h1111);
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (valid_w && addr_w == 19'd36) begin
        sof = 1'b1;
        cycle();
        sof = 1'b0;
        found = 1'b1;
      end
    end
    repeat (3) cycle();
    ae = 1'b1;
    repeat (6) cycle();
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL sof_reach_36: got no write at 36 within 60 cycles, expected one"); end
    k = -1;
    for (int i = 0; i < w_addr.size(); i++) if (w_addr[i] == 37 && k < 0) k = i;
    n_checks++;
    if (k < 0 || k + 2 >= w_addr.size()) begin
      n_fail++; $display("FAIL sof_write37: got index %0d of %0d writes, expected write at 37 followed by two more", k, w_addr.size());
    end else begin
      n_checks++; if (w_addr[k + 1] != 0) begin n_fail++; $display("FAIL sof_next_addr: got %0d expected 0", w_addr[k + 1]); end
      n_checks++; if (w_addr[k + 2] != 1) begin n_fail++; $display("FAIL sof_next_addr2: got %0d expected 1", w_addr[k + 2]); end
    end
    n_checks++;
    if (bbw_n != 0) begin n_fail++; $display("FAIL sof_no_bbox: got %0d pulses expected 0", bbw_n); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b0;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    repeat (20) src_q.push_back(16'h1234);
    start_frame();
    repeat (4) cycle();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", valid); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL ar_rd: got %b expected 0", rd); end
    n_checks++; if (addr !== 19'd0) begin n_fail++; $display("FAIL ar_addr: got %0d expected 0", addr); end
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL ar_data: got %h expected 0000", data); end
    cycle();
    rst = 1'b0;
    ae = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (valid !== 1'b0 || rd !== 1'b0) begin
        n_fail++; $display("FAIL ar_after[%0d]: got valid %b rd %b expected 0 0", i, valid, rd);
      end
    end
    ae = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sof = 1'b0; mode = 1'b0; ae = 1'b1; rdata = 16'h0000;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    n_checks = 0; n_fail = 0; cyc = 0; rd_prev = 1'b0;
    clear_logs();
    test_reset();
    test_highlight();
    test_passthrough();
    test_bbox();
    test_no_match();
    test_flush();
    test_sof_mid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
